// File: rtl/hazard_unit_p.sv
// Load-use stall / branch flush controller for the 5-stage MIPS pipeline.
// Optional stall-cycle performance counter built only when HAZ_PERF_EN is defined.
module hazard_unit_p #(
    parameter int LOAD_LAT = 1,
    parameter int BR_FLUSH = 1,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_ins,
    input  logic [31:0] ex_ins,
    input  logic        ex_valid,
    input  logic        br_taken,
    output logic        stall,
    output logic        bubble,
    output logic        flush,
    output logic [31:0] nop_ins,
    output logic [15:0] perf_stalls
);

    typedef enum logic [1:0] {IDLE, LSTALL, FLUSH} state_t;

    state_t            state_p0, state_nxt;
    logic [CNT_W-1:0]  cnt_p0, cnt_nxt;

    logic [5:0] id_op, ex_op;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       hit;
    logic       unused_bits;

    // R-type, sw, beq and bne read rt as well as rs
    function automatic logic rt_is_src(input logic [5:0] op);
        return (op == 6'b000000) || (op == 6'b101011) ||
               (op == 6'b000100) || (op == 6'b000101);
    endfunction

    assign id_op = id_ins[31:26];
    assign id_rs = id_ins[25:21];
    assign id_rt = id_ins[20:16];
    assign ex_op = ex_ins[31:26];
    assign ex_rt = ex_ins[20:16];

    assign unused_bits = &{1'b0, id_ins[15:0], ex_ins[25:21], ex_ins[15:0]};

    // ex_rt != 0 keeps $0 from ever matching
    assign hit = ex_valid && (ex_op == 6'b100011) && (ex_rt != 5'd0) &&
                 ((id_rs == ex_rt) || (rt_is_src(id_op) && (id_rt == ex_rt)));

    assign nop_ins = 32'h0000_0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p0 <= IDLE;
            cnt_p0   <= '0;
        end else begin
            state_p0 <= state_nxt;
            cnt_p0   <= cnt_nxt;
        end
    end

    always_comb begin
        stall     = 1'b0;
        bubble    = 1'b0;
        flush     = 1'b0;
        state_nxt = state_p0;
        cnt_nxt   = cnt_p0;
        // A taken branch overrides any stall in progress and restarts the flush window
        if (br_taken) begin
            flush = 1'b1;
            if (BR_FLUSH > 1) begin
                state_nxt = FLUSH;
                cnt_nxt   = CNT_W'(BR_FLUSH - 1);
            end else begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        end else begin
            case (state_p0)
                IDLE: begin
                    if (hit) begin
                        stall  = 1'b1;
                        bubble = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_nxt = LSTALL;
                            cnt_nxt   = CNT_W'(LOAD_LAT - 1);
                        end
                    end
                end
                LSTALL: begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    if (cnt_p0 <= CNT_W'(1)) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_p0 - CNT_W'(1);
                    end
                end
                FLUSH: begin
                    flush = 1'b1;
                    if (cnt_p0 <= CNT_W'(1)) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_p0 - CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
        if (rst) begin
            stall  = 1'b0;
            bubble = 1'b0;
            flush  = 1'b0;
        end
    end

`ifdef HAZ_PERF_EN
    logic [15:0] perf_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf_p0 <= '0;
        else if (stall && (perf_p0 != 16'hFFFF))
            perf_p0 <= perf_p0 + 16'd1;
    end

    assign perf_stalls = perf_p0;
`else
    assign perf_stalls = 16'h0000;
`endif

endmodule
